// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial BCD adder.
package bcd_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_ADJ = 4'd6;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/bcd_digit_cell.sv
// Combinational single-digit BCD add: s/co = a + b + ci with decimal adjust.
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       ci,
    output bcd_digit_t s,
    output logic       co
);

    logic [4:0] y;

    always_comb begin
        y  = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
        co = (y > {1'b0, BCD_MAX});
        s  = co ? (y[3:0] + BCD_ADJ) : y[3:0];
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial multi-digit BCD adder, LSD first, one digit per clock.
// Optional BCD_SUBTRACT_EN adds a `sub` port for ten's-complement A - B.
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [4*DIGITS-1:0] a_in,
    input  logic [4*DIGITS-1:0] b_in,
    input  logic              cin,
`ifdef BCD_SUBTRACT_EN
    input  logic              sub,
`endif
    output logic              busy,
    output logic              done,
    output logic [4*DIGITS-1:0] sum_out,
    output logic              cout,
    output logic              err
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             err_q, err_d;
`ifdef BCD_SUBTRACT_EN
    logic             sub_q, sub_d;
`endif

    bcd_digit_t a_dig, b_dig, b_eff, s_dig;
    logic       co_dig, dig_bad;

    always_comb begin
        a_dig   = a_q[{idx_q, 2'b00} +: 4];
        b_dig   = b_q[{idx_q, 2'b00} +: 4];
        dig_bad = (a_dig > BCD_MAX) || (b_dig > BCD_MAX);
`ifdef BCD_SUBTRACT_EN
        // Nines' complement wraps mod 16 for invalid digits.
        b_eff   = sub_q ? (BCD_MAX - b_dig) : b_dig;
`else
        b_eff   = b_dig;
`endif
    end

    bcd_digit_cell u_cell (
        .a  (a_dig),
        .b  (b_eff),
        .ci (carry_q),
        .s  (s_dig),
        .co (co_dig)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (idx_q == LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        err_d   = err_q;
`ifdef BCD_SUBTRACT_EN
        sub_d   = sub_q;
`endif
        if (state_q == IDLE && start) begin
            a_d     = a_in;
            b_d     = b_in;
            idx_d   = '0;
            err_d   = 1'b0;
`ifdef BCD_SUBTRACT_EN
            sub_d   = sub;
            carry_d = sub ? 1'b1 : cin;
`else
            carry_d = cin;
`endif
        end else if (state_q == RUN) begin
            sum_d[{idx_q, 2'b00} +: 4] = s_dig;
            carry_d = co_dig;
            err_d   = err_q | dig_bad;
            if (idx_q == LAST) begin
                idx_d  = '0;
                cout_d = co_dig;
            end else begin
                idx_d  = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef BCD_SUBTRACT_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
`ifdef BCD_SUBTRACT_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign sum_out = sum_q;
    assign cout    = cout_q;
    assign err     = err_q;

endmodule
